// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 (double-dabble) binary to packed BCD
// converter with a leading-zero blanking mask and an overflow flag for values
// that do not fit in DIGITS decimal digits.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              acc_ovf_q, acc_ovf_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              ovf_q, ovf_d;

  logic [BW-1:0]       adj;
  logic [BW+WIDTH-1:0] shifted;
  logic [BW-1:0]       new_bcd;
  logic [WIDTH-1:0]    new_shreg;
  logic                step_ovf;
  logic                last;
  logic [DIGITS-1:0]   step_blank;
  logic                zero_run;

  // One double-dabble step: add 3 to every digit >= 5, then shift left by one.
  always_comb begin
    adj = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted   = {adj, shreg_q} << 1;
    new_bcd   = shifted[BW+WIDTH-1 -: BW];
    new_shreg = shifted[WIDTH-1:0];
    // The adjusted top-digit MSB is exactly the carry into the dropped digit.
    step_ovf  = acc_ovf_q | adj[BW-1];
    last      = (cnt_q == CW'(1));
  end

  // Leading-zero mask of the step result, scanning from the top digit down.
  always_comb begin
    step_blank = '0;
    zero_run   = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (new_bcd[4*i +: 4] == 4'd0);
      step_blank[i] = zero_run & ~step_ovf;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accepted start, step while shifting.
  always_comb begin
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    acc_ovf_d = acc_ovf_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          acc_ovf_d = 1'b0;
          cnt_d     = CW'(WIDTH);
        end
      end
      SHIFT: begin
        shreg_d   = new_shreg;
        scratch_d = new_bcd;
        acc_ovf_d = step_ovf;
        cnt_d     = cnt_q - CW'(1);
        if (last) begin
          bcd_d   = new_bcd;
          blank_d = step_blank;
          ovf_d   = step_ovf;
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      acc_ovf_q <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      acc_ovf_q <= acc_ovf_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      ovf_q     <= ovf_d;
    end
  end

  // Outputs: decoded from the state register and driven from result flops.
  always_comb begin
    busy  = (state_q == SHIFT) || (state_q == DONE);
    done  = (state_q == DONE);
    bcd   = bcd_q;
    blank = blank_q;
    ovf   = ovf_q;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential shift-and-add-3 (double-dabble) converter from an unsigned binary value to packed BCD digits. It sits directly upstream of the 4-bit seven-segment decoders. Each BCD nibble drives one decoder's 4-bit code input. A leading-zero mask is also produced so the display stage can blank unused digits.

Parameters:
WIDTH, 8, bit width of the binary input (>=1)
DIGITS, 3, number of BCD output digits (>=1); if 10^DIGITS <= 2^WIDTH - 1, out-of-range values are reported via ovf

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  conversion request; sampled only in IDLE
bin  input  WIDTH  binary value; sampled on the edge that accepts start
busy  output  1  high in SHIFT and DONE states
done  output  1  one-cycle pulse; bcd/blank/ovf are new in this cycle
bcd  output  4*DIGITS  packed result; digit i = bcd[4i+3:4i], digit 0 = units
blank  output  DIGITS  bit i high = digit i is a leading zero; bit 0 always 0
ovf  output  1  high if the last converted value was >= 10^DIGITS

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, bcd=0, blank=0, ovf=0; internal shift and scratch registers and counter = 0. Reset asserted mid-conversion aborts it. No done pulse is produced and outputs clear immediately.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on a clock edge with start=1:
  - latch bin into the shift register;
  - clear the BCD scratch register and the overflow flag;
  - load the counter with WIDTH;
  - go to SHIFT.
- IDLE with start=0: hold. Outputs bcd/blank/ovf keep their last results.
- SHIFT, once per cycle:
  - first, every scratch digit >= 5 gets +3 (4-bit add, no carry between digits);
  - then {scratch, shiftreg} shifts left by 1.
  - The bit shifted out of the top digit MSB is ORed into the overflow flag.
  - Counter decrements.
  - On the edge where the counter goes 1->0, the final shifted value is loaded into bcd, blank and ovf are computed, and the state goes to DONE.
- Overflow semantics: when ovf=1, bcd = value mod 10^DIGITS, since truncated double-dabble drops whole multiples of 10^DIGITS.
- blank: bit i (i>=1) = 1 iff digits i..DIGITS-1 are all zero. It is computed from the final result, registered with bcd, and forced 0 whenever ovf=1.
- DONE: done=1 for exactly this one cycle; then IDLE unconditionally. start is ignored here.
- Latency: start sampled at edge k leads to done high in the cycle after edge k+WIDTH, i.e. WIDTH cycles. Throughput: one conversion per WIDTH+2 cycles. start may be held high continuously.
- start asserted while busy=1 is ignored, not queued. bin changes during a conversion have no effect.
- Outputs bcd/blank/ovf change only on the edge entering DONE, or on reset.
- All outputs are registered. No combinational path from start/bin to any output.

Test Plan:
1. WIDTH=8, DIGITS=3; bin=8'd255, start pulse at edge k -> done high only in the cycle after edge k+8; bcd=12'h255, blank=3'b000, ovf=0; busy high for 9 cycles.
2. WIDTH=8, DIGITS=3; bin=8'd0, then bin=8'd7, then bin=8'd42 -> bcd=12'h000/blank=3'b110; bcd=12'h007/blank=3'b110; bcd=12'h042/blank=3'b100.
3. WIDTH=8, DIGITS=2; bin=8'd199 -> bcd=8'h99, ovf=1, blank=2'b00. Then bin=8'd99 -> bcd=8'h99, ovf=0.
4. Start on 8'd128, then pulse start with bin=8'd5 three cycles later -> second request ignored; result bcd=12'h128. Holding start high through the following IDLE starts a new conversion on 8'd5 in the next cycle.
5. Start on 8'd200, assert rst two cycles in -> busy, done, bcd, blank, ovf all 0 immediately. After release, a start on 8'd17 gives bcd=12'h017 after 8 cycles.
6. Exhaustive sweep, WIDTH=8, DIGITS=3: every bin 0..255 -> bcd matches the reference decimal conversion, exactly one done per start, no X on any output after reset.
